// File: rtl/vga_cfg_pkg.sv
// Shared types and constants for the VGA configuration loader.
package vga_cfg_pkg;

    localparam int unsigned CFG_WIDTH_DEF = 32;
    // Solid-colour mode, white.
    localparam logic [31:0] RESET_CFG_DEF = 32'h7F00_0000;

    // Field positions inside the configuration word.
    localparam int unsigned SEL_MSB   = 31;
    localparam int unsigned SEL_LSB   = 30;
    localparam int unsigned COLOR_MSB = 29;
    localparam int unsigned COLOR_LSB = 24;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StOverrun
    } cfg_state_e;

endpackage

// File: rtl/vga_config_loader_if.sv
// 3-wire SPI link between the Arduino (master) and the loader (slave).
interface vga_config_loader_if;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_cs_n;
    logic spi_miso;

    modport master (output spi_sclk, output spi_mosi, output spi_cs_n, input spi_miso);
    modport slave  (input spi_sclk, input spi_mosi, input spi_cs_n, output spi_miso);
endinterface

// File: rtl/vga_config_loader_sync_edge_det.sv
// Multi-stage synchroniser with one history flop and rise/fall pulses.
// Stages must be at least 2.
module sync_edge_det #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [Stages-1:0] sync_q;
    logic              hist_q;

    // Synchroniser chain plus history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {Stages{ResetVal}};
            hist_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[Stages-2:0], din};
            hist_q <= sync_q[Stages-1];
        end
    end

    assign dout = sync_q[Stages-1];
    assign rise = dout & ~hist_q;
    assign fall = ~dout & hist_q;

endmodule

// File: rtl/vga_config_loader.sv
// Receives a configuration word over SPI (mode 0, MSB first), holds it as
// pending and commits it to the live configuration bus on the vsync falling
// edge. Optional readback of the live word on spi_miso: VGA_CFG_READBACK_EN.
module vga_config_loader
    import vga_cfg_pkg::*;
#(
    parameter int unsigned           CFG_WIDTH   = CFG_WIDTH_DEF,
    parameter int unsigned           SYNC_STAGES = 2,  // 2 or 3
    parameter logic [CFG_WIDTH-1:0]  RESET_CFG   = CFG_WIDTH'(RESET_CFG_DEF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_config_loader_if.slave   spi,
    input  logic                 vs,
    output logic [CFG_WIDTH-1:0] configuration,
    output logic                 cfg_pending,
    output logic                 cfg_update,
    output logic                 cfg_err
);

    localparam int unsigned          CntWidth = $clog2(CFG_WIDTH + 1);
    localparam logic [CntWidth-1:0]  FullCnt  = CntWidth'(CFG_WIDTH);

    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic cs_n_s, cs_rise, cs_fall;

    sync_edge_det #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi.spi_sclk),
        .dout (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    sync_edge_det #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi.spi_mosi),
        .dout (mosi_s),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    // cs_n idles high so reset must not fabricate a frame start.
    sync_edge_det #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi.spi_cs_n),
        .dout (cs_n_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_s, sclk_fall, mosi_rise, mosi_fall, cs_n_s};

    cfg_state_e           state_q;
    logic [CFG_WIDTH-1:0] shift_q;
    logic [CntWidth-1:0]  bit_cnt_q;
    logic [CFG_WIDTH-1:0] pending_q;
    logic [CFG_WIDTH-1:0] configuration_q;
    logic                 cfg_pending_q;
    logic                 cfg_update_q;
    logic                 cfg_err_q;
    logic                 vs_q;
    logic                 commit;

    assign commit = vs_q & ~vs & cfg_pending_q;

    // Receive FSM, pending register and vsync-aligned commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            pending_q       <= '0;
            configuration_q <= RESET_CFG;
            cfg_pending_q   <= 1'b0;
            cfg_update_q    <= 1'b0;
            cfg_err_q       <= 1'b0;
            vs_q            <= 1'b1;
        end else begin
            vs_q         <= vs;
            cfg_update_q <= 1'b0;
            cfg_err_q    <= 1'b0;

            // Commit uses the old pending word; a same-cycle load below wins
            // the pending flag so the new word stays queued.
            if (commit) begin
                configuration_q <= pending_q;
                cfg_update_q    <= 1'b1;
                cfg_pending_q   <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_q   <= StShift;
                        bit_cnt_q <= '0;
                    end
                end
                StShift: begin
                    if (cs_rise) begin
                        if (bit_cnt_q == FullCnt) begin
                            pending_q     <= shift_q;
                            cfg_pending_q <= 1'b1;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end else if (sclk_rise) begin
                        if (bit_cnt_q == FullCnt) begin
                            state_q <= StOverrun;
                        end else begin
                            shift_q   <= {shift_q[CFG_WIDTH-2:0], mosi_s};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                StOverrun: begin
                    if (cs_rise) begin
                        cfg_err_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign configuration = configuration_q;
    assign cfg_pending   = cfg_pending_q;
    assign cfg_update    = cfg_update_q;
    assign cfg_err       = cfg_err_q;

`ifdef VGA_CFG_READBACK_EN
    logic [CFG_WIDTH-1:0] rb_q;

    // Snapshot the live word at frame start; shift on falling sclk so the
    // next bit is ready before the master samples on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_q <= '0;
        end else if (cs_fall) begin
            rb_q <= configuration_q;
        end else if (!cs_n_s && sclk_fall) begin
            rb_q <= {rb_q[CFG_WIDTH-2:0], 1'b0};
        end
    end

    assign spi.spi_miso = ~cs_n_s & rb_q[CFG_WIDTH-1];
`else
    assign spi.spi_miso = 1'b0;
`endif

endmodule

// File: doc/vga_config_loader.md
Name: vga_config_loader

Overview:
- Receives the 32-bit GPU configuration word from the Arduino over a 3-wire SPI-style link (sclk/mosi/cs_n, mode 0, MSB first).
- Holds a received word as pending and commits it to the live `configuration` bus only at the start of the vertical sync pulse, so the pixel mux never changes mid-frame.
- Sits between the top-level `ui_in` pins and the VGA controller's `configuration` input.

Parameters:
- CFG_WIDTH, 32, configuration word length in bits.
- SYNC_STAGES, 2, synchroniser depth for sclk/mosi/cs_n; legal values are 2 or 3.
- RESET_CFG, 32'h7F00_0000, value driven on `configuration` after reset (select=01 solid colour, colour=6'h3F white).

Ports:
- clk, input, 1, pixel clock.
- rst_n, input, 1, asynchronous active-low reset.
- spi_sclk, input, 1, serial clock from the Arduino; asynchronous to clk.
- spi_mosi, input, 1, serial data; sampled on rising spi_sclk.
- spi_cs_n, input, 1, frame select, active low.
- vs, input, 1, vertical sync from the timing generator, active low, clk domain.
- spi_miso, output, 1, readback data (see Optional Feature).
- configuration, output, CFG_WIDTH, live configuration word.
- cfg_pending, output, 1, a validated word is waiting for commit.
- cfg_update, output, 1, one-cycle pulse on the cycle `configuration` changes.
- cfg_err, output, 1, one-cycle pulse when a malformed frame is discarded.

Behaviour:
- Reset (async assert, sync release):
  - configuration=RESET_CFG.
  - shift register=0, bit_cnt=0, pending register=0.
  - cfg_pending=0, cfg_update=0, cfg_err=0, spi_miso=0.
  - FSM=IDLE; vs edge register=1.
- Inputs spi_* pass through SYNC_STAGES flops plus one history flop. Edge detects use the synchronised values, so an SPI edge acts SYNC_STAGES+1 clk after the pin change.
- Requirement: sclk high and low phases each ≥ SYNC_STAGES+2 clk periods. Faster sclk is out of contract.
- FSM states and transitions:
  - IDLE: synced cs_n falling → SHIFT, bit_cnt=0.
  - SHIFT: each synced sclk rising edge does shift_reg={shift_reg[CFG_WIDTH-2:0], mosi_s} and bit_cnt+1.
    - If bit_cnt would exceed CFG_WIDTH → OVERRUN.
    - cs_n rising with bit_cnt==CFG_WIDTH → load pending register, cfg_pending=1, → IDLE.
    - cs_n rising with bit_cnt≠CFG_WIDTH → cfg_err pulse, discard, → IDLE.
  - OVERRUN: ignore sclk; on cs_n rising → cfg_err pulse, → IDLE.
- bit_cnt width = $clog2(CFG_WIDTH+1). It saturates and does not wrap.
- Commit: vs_q registered each cycle. On the cycle with vs_q==1 && vs==0 (falling edge) and cfg_pending==1:
  - configuration <= pending register.
  - cfg_update=1 for that cycle.
  - cfg_pending <= 0.
- Commit latency: configuration changes exactly 1 clk after the vs falling-edge cycle.
- Simultaneous commit and new load in the same cycle: the old pending value commits, the new word becomes pending, and cfg_pending stays 1.
- A new valid frame while cfg_pending=1 overwrites the pending word (last wins). No error is raised.
- cs_n glitch (low then high with 0 bits) is treated as a short frame: cfg_err pulses, configuration is unchanged.
- A reset mid-transfer discards the partial word. A following partial frame after release is handled per the FSM.

Optional Feature:
- Macro: VGA_CFG_READBACK_EN.
- Defined:
  - On the synced cs_n falling edge, a readback register loads `configuration`.
  - spi_miso drives its MSB.
  - The register shifts left on each synced sclk falling edge, so the Arduino reads the live word during the write.
  - spi_miso=0 when cs_n is high.
- Undefined: spi_miso tied to 0 and no readback register is inferred.

Decomposition:
- Package vga_cfg_pkg holds:
  - CFG_WIDTH default.
  - FSM state enum (IDLE, SHIFT, OVERRUN).
  - RESET_CFG default.
  - Field localparams: SEL_MSB=31, SEL_LSB=30, COLOR_MSB=29, COLOR_LSB=24.
- Sub-module sync_edge_det: N-stage synchroniser plus rise/fall pulse outputs, instantiated three times.

Test Plan:
- Reset → configuration=32'h7F00_0000, cfg_pending=0, spi_miso=0, no pulses.
- Send 32'hC0FF_0000 mid-frame → cfg_pending=1, configuration unchanged until the next vs fall. Then cfg_update pulses once and configuration=32'hC0FF_0000 one clk later.
- Frames with 31 bits and with 33 bits → cfg_err pulses once each, cfg_pending stays 0, configuration unchanged.
- Send 32'h4100_0000 then 32'h8200_0000 before vs fall → the commit yields 32'h8200_0000 and only one cfg_update pulse.
- cs_n rising to complete 32'h1234_5678 on the same cycle as the vs fall, with 32'hAAAA_5555 already pending → configuration=32'hAAAA_5555, cfg_pending=1. The next vs fall gives 32'h1234_5678.
- With VGA_CFG_READBACK_EN and configuration=32'h7F00_0000 → spi_miso bit sequence during the transfer = 0,1,1,1,1,1,1,1,0×24.
